// File: rtl/pc_pkg.sv
// Shared encodings for the PC fetch sequencer.
// Next-PC select codes and fetch FSM states.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SRC_PC4    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_HOLD   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    WAIT  = 2'b01,
    EXEC  = 2'b10
  } state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selector: picks one upstream candidate.
// No arithmetic here; all candidates arrive precomputed.
module pc_next_mux
  import pc_pkg::*;
(
  input  logic [1:0]  i_pc_src,
  input  logic        i_branch_cond,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc4,
  input  logic [31:0] i_branch_addr,
  input  logic [31:0] i_jump_addr,
  output logic [31:0] o_next_pc
);

  // Select the next PC; untaken branch falls through to pc4
  always_comb begin
    o_next_pc = i_pc;
    case (i_pc_src)
      PC_SRC_PC4:    o_next_pc = i_pc4;
      PC_SRC_BRANCH: o_next_pc = i_branch_cond ?
                                 i_branch_addr : i_pc4;
      PC_SRC_JUMP:   o_next_pc = i_jump_addr;
      PC_SRC_HOLD:   o_next_pc = i_pc;
      default:       o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// PC register, fetch handshake FSM and instruction register.
// Optional misaligned-PC trap enabled by macro PC_ALIGN_CHECK_EN.
module pc_fetch_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic [1:0]  pc_src,
  input  logic        branch_cond,
  input  logic [31:0] pc4,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_exc,
  output logic [31:0] epc
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] w_next_pc;
  logic [31:0] w_commit_pc;
  logic        w_commit;

  assign w_commit = (r_state == EXEC) && pc_write;

  pc_next_mux u_next_mux (
    .i_pc_src      (pc_src),
    .i_branch_cond (branch_cond),
    .i_pc          (r_pc),
    .i_pc4         (pc4),
    .i_branch_addr (branch_addr),
    .i_jump_addr   (jump_addr),
    .o_next_pc     (w_next_pc)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic        w_misalign;
  logic        r_exc;
  logic [31:0] r_epc;

  assign w_misalign  = |w_next_pc[1:0];
  assign w_commit_pc = w_misalign ? EXC_VECTOR : w_next_pc;

  // Trap pulse for the cycle after a misaligned commit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_exc <= 1'b0;
      r_epc <= '0;
    end else begin
      r_exc <= w_commit && w_misalign;
      if (w_commit && w_misalign)
        r_epc <= w_next_pc;
    end
  end

  assign misalign_exc = r_exc;
  assign epc          = r_epc;
`else
  logic [1:0] w_unused_lo;

  assign w_unused_lo  = w_next_pc[1:0];
  assign w_commit_pc  = {w_next_pc[31:2], 2'b00};
  assign misalign_exc = 1'b0;
  assign epc          = '0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_state_nxt;
  end

  // Next state: grant only counts while request is up
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH: if (r_req && imem_gnt) w_state_nxt = WAIT;
      WAIT:  if (imem_rvalid)       w_state_nxt = EXEC;
      EXEC:  if (pc_write)          w_state_nxt = FETCH;
      default:                      w_state_nxt = FETCH;
    endcase
  end

  // PC, request/address and instruction register updates
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (r_req && imem_gnt) begin
            r_req <= 1'b0;
          end else begin
            r_req  <= 1'b1;
            r_addr <= r_pc;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (w_commit) begin
            r_pc    <= w_commit_pc;
            r_addr  <= w_commit_pc;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign pc          = r_pc;
  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr       = r_instr;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer.
// Bench acts as instruction memory and control unit.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        branch_cond;
  logic [31:0] pc4, branch_addr, jump_addr;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_exc;
  logic [31:0] epc;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_epc;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .branch_cond  (branch_cond),
    .pc4          (pc4),
    .branch_addr  (branch_addr),
    .jump_addr    (jump_addr),
    .pc           (pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .misalign_exc (misalign_exc),
    .epc          (epc)
  );

  function automatic logic [31:0] ref_sel(
    input logic [1:0]  src,
    input logic        cond,
    input logic [31:0] p4,
    input logic [31:0] br,
    input logic [31:0] jmp,
    input logic [31:0] cur
  );
    if (src == 2'd0) return p4;
    if (src == 2'd1) return cond ? br : p4;
    if (src == 2'd2) return jmp;
    return cur;
  endfunction

  function automatic logic [31:0] ref_land(input logic [31:0] nxt);
`ifdef PC_ALIGN_CHECK_EN
    return (nxt % 4 != 0) ? EXC_PC : nxt;
`else
    return nxt - (nxt % 4);
`endif
  endfunction

  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL req_timeout: imem_req=%b want 1", imem_req);
    end
  endtask

  task automatic fetch(input int gdly, input int rdly,
                       input logic [31:0] data, input bit noise);
    wait_req();
    n_chk++;
    if (imem_addr !== m_pc || pc !== m_pc) begin
      n_fail++;
      $display("FAIL fetch_addr: addr=%h pc=%h want %h",
               imem_addr, pc, m_pc);
    end
    for (int i = 0; i < gdly; i++) begin
      imem_gnt = 1'b0;
      if (noise) begin
        pc_write    = 1'b1;
        pc_src      = 2'($urandom_range(0, 3));
        branch_cond = 1'($urandom);
        pc4         = $urandom;
        branch_addr = $urandom;
        jump_addr   = $urandom;
        imem_rvalid = 1'b1;
        imem_rdata  = ~data;
      end
      @(negedge clk);
      pc_write    = 1'b0;
      imem_rvalid = 1'b0;
      n_chk++;
      if (imem_req !== 1'b1 || pc !== m_pc || instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL req_hold: req=%b pc=%h iv=%b want 1 %h 0",
                 imem_req, pc, instr_valid, m_pc);
      end
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    n_chk++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_drop: imem_req=%b want 0", imem_req);
    end
    for (int i = 0; i < rdly; i++) begin
      if (noise) begin
        pc_write = 1'b1;
        pc_src   = 2'($urandom_range(0, 3));
        pc4      = $urandom;
        jump_addr = $urandom;
      end
      @(negedge clk);
      pc_write = 1'b0;
      n_chk++;
      if (pc !== m_pc || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_hold: pc=%h iv=%b req=%b want %h 0 0",
                 pc, instr_valid, imem_req, m_pc);
      end
    end
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    m_instr     = data;
    n_chk++;
    if (instr_valid !== 1'b1 || instr !== data || pc !== m_pc) begin
      n_fail++;
      $display("FAIL instr_load: iv=%b instr=%h pc=%h want 1 %h %h",
               instr_valid, instr, pc, data, m_pc);
    end
  endtask

  task automatic commit(input logic [1:0] src, input logic cond,
                        input logic [31:0] p4, input logic [31:0] br,
                        input logic [31:0] jmp, input int idle);
    logic [31:0] nxt;
    bit          mis;
    for (int i = 0; i < idle; i++) begin
      @(negedge clk);
      n_chk++;
      if (instr !== m_instr || instr_valid !== 1'b1 || pc !== m_pc) begin
        n_fail++;
        $display("FAIL exec_stable: instr=%h iv=%b want %h 1",
                 instr, instr_valid, m_instr);
      end
    end
    pc_src      = src;
    branch_cond = cond;
    pc4         = p4;
    branch_addr = br;
    jump_addr   = jmp;
    pc_write    = 1'b1;
    nxt = ref_sel(src, cond, p4, br, jmp, m_pc);
    mis = (nxt % 4) != 0;
    @(negedge clk);
    pc_write = 1'b0;
    m_pc = ref_land(nxt);
    n_chk++;
    if (pc !== m_pc || instr_valid !== 1'b0 ||
        imem_req !== 1'b1 || imem_addr !== m_pc) begin
      n_fail++;
      $display("FAIL commit: pc=%h iv=%b req=%b addr=%h want %h 0 1 %h",
               pc, instr_valid, imem_req, imem_addr, m_pc, m_pc);
    end
`ifdef PC_ALIGN_CHECK_EN
    if (mis) m_epc = nxt;
    n_chk++;
    if (misalign_exc !== mis || epc !== m_epc) begin
      n_fail++;
      $display("FAIL exc_pulse: exc=%b epc=%h want %b %h",
               misalign_exc, epc, mis, m_epc);
    end
    @(negedge clk);
    n_chk++;
    if (misalign_exc !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_width: exc=%b want 0", misalign_exc);
    end
`else
    n_chk++;
    if (misalign_exc !== 1'b0 || epc !== 32'h0) begin
      n_fail++;
      $display("FAIL exc_tied: exc=%b epc=%h want 0 0 (mis=%b)",
               misalign_exc, epc, mis);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (pc !== RST_PC || imem_req !== 1'b0 || imem_addr !== 32'h0 ||
        instr !== 32'h0 || instr_valid !== 1'b0 ||
        misalign_exc !== 1'b0 || epc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: pc=%h req=%b addr=%h ir=%h iv=%b exc=%b epc=%h",
               pc, imem_req, imem_addr, instr, instr_valid,
               misalign_exc, epc);
    end
    reset   = 1'b0;
    m_pc    = RST_PC;
    m_instr = 32'h0;
    m_epc   = 32'h0;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h want 1 %h",
               imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_first_fetch();
    fetch(0, 0, 32'h2008_0005, 1'b0);
  endtask

  task automatic test_branch();
    commit(2'b01, 1'b1, 32'h4, 32'h40, 32'h0, 0);
    fetch(0, 0, $urandom, 1'b0);
    commit(2'b01, 1'b0, 32'h4, 32'h80, 32'h0, 1);
    fetch(0, 1, $urandom, 1'b0);
  endtask

  task automatic test_jump_hold();
    commit(2'b10, 1'b1, 32'h8, 32'h44, 32'h0040_0020, 0);
    fetch(1, 0, $urandom, 1'b0);
    commit(2'b11, 1'b1, 32'h8, 32'h44, 32'h1234_5678, 2);
    fetch(0, 0, $urandom, 1'b0);
  endtask

  task automatic test_write_in_wait();
    commit(2'b00, 1'b0, m_pc + 32'h4, 32'h0, 32'h0, 0);
    fetch(3, 2, 32'hDEAD_BEEF, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    commit(2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_0200, 0);
    wait_req();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    m_pc     = RST_PC;
    m_instr  = 32'h0;
    m_epc    = 32'h0;
    n_chk++;
    if (pc !== RST_PC || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wait: pc=%h iv=%b req=%b want %h 0 0",
               pc, instr_valid, imem_req, RST_PC);
    end
    fetch(0, 0, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_misalign();
    commit(2'b10, 1'b0, 32'h0, 32'h0, 32'h0000_0102, 0);
    fetch(0, 0, $urandom, 1'b0);
  endtask

  task automatic test_wrap();
    commit(2'b10, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0);
    fetch(0, 0, $urandom, 1'b0);
    commit(2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 0);
    fetch(0, 0, $urandom, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b, c;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      c = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        a[1:0] = 2'b00;
        b[1:0] = 2'b00;
        c[1:0] = 2'b00;
      end
      commit(2'($urandom_range(0, 3)), 1'($urandom), a, b, c,
             $urandom_range(0, 2));
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            1'($urandom));
    end
  endtask

  initial begin
    reset       = 1'b1;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    branch_cond = 1'b0;
    pc4         = 32'h0;
    branch_addr = 32'h0;
    jump_addr   = 32'h0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    m_pc        = RST_PC;
    m_instr     = 32'h0;
    m_epc       = 32'h0;
    test_reset();
    test_first_fetch();
    test_branch();
    test_jump_hold();
    test_write_in_wait();
    test_reset_in_wait();
    test_misalign();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
